// File: rtl/dram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dram_port_arbiter_if
// Purpose  : Requester and RAM-side signal bundle for the data-RAM arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface dram_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_we;
    logic [DATA_W-1:0] ram_data_out;
    logic              busy;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_addr, ram_data_in, ram_we, busy,
        input  ram_data_out
    );

    // Requesters plus RAM model side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_addr, ram_data_in, ram_we, busy,
        output ram_data_out
    );
endinterface
`default_nettype wire

// File: rtl/dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_port_arbiter
// Purpose  : Round-robin two-master sequencer for the single-port data RAM,
//            one transaction in flight, read data returned after RD_LAT.
// Revision : 1.0  initial release
// ============================================================================
module dram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1    // legal range 1..3
) (
    input  wire logic          clk,
    input  wire logic          RSTN,
    dram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

    state_t            state_q,       state_d;
    logic              rr_ptr_q,      rr_ptr_d;
    logic              owner_q,       owner_d;
    logic [1:0]        wait_cnt_q,    wait_cnt_d;
    logic [ADDR_W-1:0] ram_addr_q,    ram_addr_d;
    logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
    logic              ram_we_q,      ram_we_d;
    logic              m0_gnt_q,      m0_gnt_d;
    logic              m1_gnt_q,      m1_gnt_d;
    logic              m0_rvalid_q,   m0_rvalid_d;
    logic              m1_rvalid_q,   m1_rvalid_d;
    logic [DATA_W-1:0] m0_rdata_q,    m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q,    m1_rdata_d;
    logic              busy_q,        busy_d;
    logic              win;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        wait_cnt_d    = wait_cnt_q;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        ram_we_d      = ram_we_q;
        m0_gnt_d      = 1'b0;
        m1_gnt_d      = 1'b0;
        m0_rvalid_d   = 1'b0;
        m1_rvalid_d   = 1'b0;
        m0_rdata_d    = m0_rdata_q;
        m1_rdata_d    = m1_rdata_q;
        // rr_ptr=1 means m1 is favoured on a tie
        win           = bus.m1_req && (!bus.m0_req || rr_ptr_q);

        case (state_q)
            S_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    owner_d  = win;
                    rr_ptr_d = ~win;
                    state_d  = S_ISSUE;
                    if (win) begin
                        ram_addr_d    = bus.m1_addr;
                        ram_data_in_d = bus.m1_wdata;
                        ram_we_d      = bus.m1_we;
                        m1_gnt_d      = 1'b1;
                    end else begin
                        ram_addr_d    = bus.m0_addr;
                        ram_data_in_d = bus.m0_wdata;
                        ram_we_d      = bus.m0_we;
                        m0_gnt_d      = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                // ram_we_q still marks a write during the issue cycle
                ram_we_d   = 1'b0;
                wait_cnt_d = 2'd0;
                state_d    = ram_we_q ? S_IDLE : S_WAIT;
            end

            S_WAIT: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    wait_cnt_d = 2'd0;
                    state_d    = S_IDLE;
                    if (owner_q) begin
                        m1_rdata_d  = bus.ram_data_out;
                        m1_rvalid_d = 1'b1;
                    end else begin
                        m0_rdata_d  = bus.ram_data_out;
                        m0_rvalid_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                ram_we_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= 1'b0;
            owner_q       <= 1'b0;
            wait_cnt_q    <= 2'd0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
            ram_we_q      <= 1'b0;
            m0_gnt_q      <= 1'b0;
            m1_gnt_q      <= 1'b0;
            m0_rvalid_q   <= 1'b0;
            m1_rvalid_q   <= 1'b0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            wait_cnt_q    <= wait_cnt_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
            ram_we_q      <= ram_we_d;
            m0_gnt_q      <= m0_gnt_d;
            m1_gnt_q      <= m1_gnt_d;
            m0_rvalid_q   <= m0_rvalid_d;
            m1_rvalid_q   <= m1_rvalid_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.m0_gnt      = m0_gnt_q;
    assign bus.m1_gnt      = m1_gnt_q;
    assign bus.m0_rvalid   = m0_rvalid_q;
    assign bus.m1_rvalid   = m1_rvalid_q;
    assign bus.m0_rdata    = m0_rdata_q;
    assign bus.m1_rdata    = m1_rdata_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_data_in = ram_data_in_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dram_port_arbiter
// Purpose  : Scoreboard bench: directed requests push expected grant, write
//            and read-return events; a negedge monitor matches them by cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_dram_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int EW     = ADDR_W + DATA_W;
    localparam int K_GNT  = 0;
    localparam int K_RV   = 1;
    localparam int K_WR   = 2;

    typedef struct {
        int            dut;
        int            kind;
        int            m;
        int            cyc;
        logic [EW-1:0] data;
    } exp_t;

    exp_t sb[$];

    logic clk  = 1'b0;
    logic RSTN = 1'b0;
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if1 ();
    dram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if3 ();

    dram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut1 (
        .clk (clk), .RSTN(RSTN), .bus(if1)
    );
    dram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3)) dut3 (
        .clk (clk), .RSTN(RSTN), .bus(if3)
    );

    // RAM models: unwritten words read as 0xA5000000 | addr
    logic [DATA_W-1:0] mem1 [1<<ADDR_W];
    logic [DATA_W-1:0] mem3 [1<<ADDR_W];
    bit                v1   [1<<ADDR_W];
    bit                v3   [1<<ADDR_W];
    logic [DATA_W-1:0] p1, q1, q2, q3;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    always @(posedge clk) begin
        if (if1.ram_we) begin
            mem1[if1.ram_addr] <= if1.ram_data_in;
            v1[if1.ram_addr]   <= 1'b1;
        end
        p1 <= v1[if1.ram_addr] ? mem1[if1.ram_addr] : pat(if1.ram_addr);
        if (if3.ram_we) begin
            mem3[if3.ram_addr] <= if3.ram_data_in;
            v3[if3.ram_addr]   <= 1'b1;
        end
        q1 <= v3[if3.ram_addr] ? mem3[if3.ram_addr] : pat(if3.ram_addr);
        q2 <= q1;
        q3 <= q2;
    end
    assign if1.ram_data_out = p1;
    assign if3.ram_data_out = q3;

    task automatic push_ev(input int d, input int k, input int m, input int c,
                           input logic [EW-1:0] data);
        exp_t e;
        e.dut = d; e.kind = k; e.m = m; e.cyc = c; e.data = data;
        sb.push_back(e);
    endtask

    task automatic exp_gnt(input int d, input int m, input int c);
        push_ev(d, K_GNT, m, c, '0);
    endtask

    task automatic exp_rv(input int d, input int m, input int c, input logic [DATA_W-1:0] v);
        push_ev(d, K_RV, m, c, {{ADDR_W{1'b0}}, v});
    endtask

    task automatic observe(input int d, input int k, input int m, input logic [EW-1:0] data,
                           input string nm);
        int idx;
        idx = -1;
        foreach (sb[i])
            if (idx < 0 && sb[i].dut == d && sb[i].kind == k && sb[i].m == m && sb[i].cyc == cyc)
                idx = i;
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL %s dut%0d m%0d: seen at cycle %0d (data %h), none required then",
                     nm, d, m, cyc, data);
        end else begin
            if (sb[idx].data !== data) begin
                errors++;
                $display("FAIL %s dut%0d m%0d cycle %0d: got %h, required %h",
                         nm, d, m, cyc, data, sb[idx].data);
            end
            sb.delete(idx);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, req);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (if1.m0_gnt)    observe(1, K_GNT, 0, '0, "gnt");
        if (if1.m1_gnt)    observe(1, K_GNT, 1, '0, "gnt");
        if (if1.m0_rvalid) observe(1, K_RV, 0, {{ADDR_W{1'b0}}, if1.m0_rdata}, "rvalid");
        if (if1.m1_rvalid) observe(1, K_RV, 1, {{ADDR_W{1'b0}}, if1.m1_rdata}, "rvalid");
        if (if1.ram_we)    observe(1, K_WR, 0, {if1.ram_addr, if1.ram_data_in}, "ram_wr");
        if (if3.m0_gnt)    observe(3, K_GNT, 0, '0, "gnt");
        if (if3.m1_gnt)    observe(3, K_GNT, 1, '0, "gnt");
        if (if3.m0_rvalid) observe(3, K_RV, 0, {{ADDR_W{1'b0}}, if3.m0_rdata}, "rvalid");
        if (if3.m1_rvalid) observe(3, K_RV, 1, {{ADDR_W{1'b0}}, if3.m1_rdata}, "rvalid");
        if (if3.ram_we)    observe(3, K_WR, 0, {if3.ram_addr, if3.ram_data_in}, "ram_wr");
        if (if1.m0_gnt || if1.m1_gnt)
            chk("gnt_excl_dut1", 64'(if1.m0_gnt & if1.m1_gnt), 64'd0);
        if (if3.m0_gnt || if3.m1_gnt)
            chk("gnt_excl_dut3", 64'(if3.m0_gnt & if3.m1_gnt), 64'd0);
    end

    task automatic idle_inputs();
        if1.m0_req = 0; if1.m0_we = 0; if1.m0_addr = '0; if1.m0_wdata = '0;
        if1.m1_req = 0; if1.m1_we = 0; if1.m1_addr = '0; if1.m1_wdata = '0;
        if3.m0_req = 0; if3.m0_we = 0; if3.m0_addr = '0; if3.m0_wdata = '0;
        if3.m1_req = 0; if3.m1_we = 0; if3.m1_addr = '0; if3.m1_wdata = '0;
    endtask

    // Reset dut3 while a read by master m sits in WAIT, then race both masters
    task automatic reset_mid(input int m, input logic [ADDR_W-1:0] a);
        int s;
        s = cyc;
        if (m == 0) begin if3.m0_req = 1; if3.m0_addr = a; end
        else        begin if3.m1_req = 1; if3.m1_addr = a; end
        exp_gnt(3, m, s + 1);
        @(negedge clk);
        if3.m0_req = 0; if3.m1_req = 0;
        repeat (2) @(negedge clk);
        chk("busy_before_abort", 64'(if3.busy), 64'd1);
        RSTN = 1'b0;
        #1;
        chk("busy_on_abort", 64'(if3.busy), 64'd0);
        chk("ram_we_on_abort", 64'(if3.ram_we), 64'd0);
        chk("ram_addr_on_abort", 64'(if3.ram_addr), 64'd0);
        repeat (2) @(negedge clk);
        RSTN = 1'b1;
        @(negedge clk);
        s = cyc;
        if3.m0_req = 1; if3.m0_addr = 10'h002;
        if3.m1_req = 1; if3.m1_addr = 10'h003;
        exp_gnt(3, 0, s + 1);
        exp_rv(3, 0, s + 5, 32'hA500_0002);
        @(negedge clk);
        if3.m0_req = 0; if3.m1_req = 0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: run exceeded 50000 ns");
        $fatal(1);
    end

    initial begin
        int s;
        idle_inputs();
        RSTN = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl_dut1", 64'({if1.m0_gnt, if1.m1_gnt, if1.m0_rvalid, if1.m1_rvalid,
                                  if1.ram_we, if1.busy}), 64'd0);
        chk("rst_ctrl_dut3", 64'({if3.m0_gnt, if3.m1_gnt, if3.m0_rvalid, if3.m1_rvalid,
                                  if3.ram_we, if3.busy}), 64'd0);
        chk("rst_ram_addr", 64'(if1.ram_addr), 64'd0);
        chk("rst_ram_data_in", 64'(if1.ram_data_in), 64'd0);
        chk("rst_rdata", {if1.m0_rdata, if1.m1_rdata}, 64'd0);
        RSTN = 1'b1;
        @(negedge clk);

        // m0 write 0x005 <- 0xDEADBEEF
        s = cyc;
        if1.m0_req = 1; if1.m0_we = 1; if1.m0_addr = 10'h005; if1.m0_wdata = 32'hDEAD_BEEF;
        exp_gnt(1, 0, s + 1);
        push_ev(1, K_WR, 0, s + 1, {10'h005, 32'hDEAD_BEEF});
        @(negedge clk);
        if1.m0_req = 0; if1.m0_we = 0;
        @(negedge clk);
        chk("hold_after_write", 64'({if1.ram_addr, if1.ram_we, if1.busy}), 64'({10'h005, 2'b00}));
        @(negedge clk);

        // m1 read back, RD_LAT=1
        s = cyc;
        if1.m1_req = 1; if1.m1_we = 0; if1.m1_addr = 10'h005;
        exp_gnt(1, 1, s + 1);
        exp_rv(1, 1, s + 3, 32'hDEAD_BEEF);
        @(negedge clk);
        if1.m1_req = 0;
        repeat (3) @(negedge clk);
        chk("m1_rdata_hold", 64'(if1.m1_rdata), 64'hDEAD_BEEF);
        chk("m0_rdata_untouched", 64'(if1.m0_rdata), 64'd0);

        // Both masters hold read requests for 6 grants
        s = cyc;
        if1.m0_req = 1; if1.m0_addr = 10'h010;
        if1.m1_req = 1; if1.m1_addr = 10'h020;
        for (int k = 0; k < 6; k++) begin
            exp_gnt(1, k % 2, s + 1 + 3 * k);
            exp_rv(1, k % 2, s + 3 + 3 * k, (k % 2) ? 32'hA500_0020 : 32'hA500_0010);
        end
        repeat (16) @(negedge clk);
        if1.m0_req = 0; if1.m1_req = 0;
        repeat (4) @(negedge clk);

        // m1 back-to-back reads, address advanced after each grant
        s = cyc;
        if1.m1_req = 1; if1.m1_addr = 10'h030;
        for (int k = 0; k < 3; k++) begin
            exp_gnt(1, 1, s + 1 + 3 * k);
            exp_rv(1, 1, s + 3 + 3 * k, 32'hA500_0030 + 32'(k));
        end
        @(negedge clk);
        if1.m1_addr = 10'h031;
        repeat (3) @(negedge clk);
        if1.m1_addr = 10'h032;
        repeat (3) @(negedge clk);
        if1.m1_req = 0;
        repeat (4) @(negedge clk);

        // RD_LAT=3 read at the top address
        s = cyc;
        if3.m0_req = 1; if3.m0_we = 0; if3.m0_addr = 10'h3FF;
        exp_gnt(3, 0, s + 1);
        exp_rv(3, 0, s + 5, 32'hA500_03FF);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) if3.m0_req = 0;
            chk("busy_lat3", 64'(if3.busy), (i <= 4) ? 64'd1 : 64'd0);
        end
        repeat (2) @(negedge clk);

        reset_mid(1, 10'h004);
        reset_mid(0, 10'h001);

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            foreach (sb[i])
                $display("FAIL missing_event dut%0d kind%0d m%0d: absent, required at cycle %0d data %h",
                         sb[i].dut, sb[i].kind, sb[i].m, sb[i].cyc, sb[i].data);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
